// File: rtl/imem_loader_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : imem_loader_pkg
//  Description : Shared types and constants for the instruction-memory loader.
//  Revision    : 1.0 - initial release
// ============================================================================

package imem_loader_pkg;

    localparam int BYTES_PER_WORD = 4;
    localparam int LANE_W         = $clog2(BYTES_PER_WORD);
    localparam int LEN_W          = 16;
    localparam int INSTR_W        = 32;

    typedef enum logic [2:0] {
        LEN_LO = 3'd0,
        LEN_HI = 3'd1,
        DATA   = 3'd2,
        FLUSH  = 3'd3,
        DONE   = 3'd4,
        ERROR  = 3'd5
    } state_t;

    // Only the header and payload phases take bytes from the host link.
    function automatic logic state_accepts_bytes(input state_t s);
        return (s == LEN_LO) || (s == LEN_HI) || (s == DATA);
    endfunction

endpackage

`default_nettype wire

// File: rtl/imem_loader_if.sv
`default_nettype none
// ============================================================================
//  Module      : imem_loader_if
//  Description : Host byte stream and instruction-memory write port bundle.
//  Revision    : 1.0 - initial release
// ============================================================================

interface imem_loader_if #(
    parameter int ADDR_W = 8
);
    import imem_loader_pkg::*;

    logic [7:0]         in_data;
    logic               in_valid;
    logic               in_ready;

    logic               mem_we;
    logic [ADDR_W-1:0]  mem_addr;
    logic [INSTR_W-1:0] mem_wdata;

    // Loader side: consumes the stream, drives the memory write port.
    modport slave (
        input  in_data,
        input  in_valid,
        output in_ready,
        output mem_we,
        output mem_addr,
        output mem_wdata
    );

    // Host / memory side.
    modport master (
        output in_data,
        output in_valid,
        input  in_ready,
        input  mem_we,
        input  mem_addr,
        input  mem_wdata
    );

endinterface

`default_nettype wire

// File: rtl/imem_loader_byte_packer.sv
`default_nettype none
// ============================================================================
//  Module      : imem_loader_byte_packer
//  Description : Packs little-endian stream bytes into 32-bit words.
//  Revision    : 1.0 - initial release
// ============================================================================

module imem_loader_byte_packer
    import imem_loader_pkg::*;
(
    input  wire logic               clk,
    input  wire logic               rst,
    input  wire logic               clear,
    input  wire logic               accept,
    input  wire logic [7:0]         in_byte,
    output logic                    word_ready,
    output logic [INSTR_W-1:0]      word
);

    localparam logic [LANE_W-1:0] c_last_lane = LANE_W'(BYTES_PER_WORD - 1);

    logic [LANE_W-1:0]      r_lane;
    logic [INSTR_W-9:0]     r_asm;

    // The top byte is never stored: it is merged straight into the output
    // word on the cycle it arrives, so the word is complete with that byte.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_lane <= '0;
            r_asm  <= '0;
        end else if (clear) begin
            r_lane <= '0;
            r_asm  <= '0;
        end else if (accept) begin
            r_lane <= r_lane + 1'b1;
            for (int i = 0; i < BYTES_PER_WORD - 1; i++) begin
                if (r_lane == LANE_W'(i)) begin
                    r_asm[i*8 +: 8] <= in_byte;
                end
            end
        end
    end

    assign word_ready = accept && (r_lane == c_last_lane);
    assign word       = {in_byte, r_asm};

endmodule

`default_nettype wire

// File: rtl/imem_loader.sv
`default_nettype none
// ============================================================================
//  Module      : imem_loader
//  Description : Boot-time instruction memory writer; holds the core in reset
//                until a length-prefixed byte stream has been stored.
//  Revision    : 1.0 - initial release
// ============================================================================

module imem_loader #(
    parameter int ADDR_W = 8,
    parameter int LEN_W  = imem_loader_pkg::LEN_W
) (
    input  wire logic           clk,
    input  wire logic           rst,
    imem_loader_if.slave        bus,
    input  wire logic           start,
    output logic                core_rst,
    output logic                done,
    output logic                error,
    output logic [ADDR_W:0]     word_cnt
);
    import imem_loader_pkg::*;

    localparam logic [32:0] c_depth = 33'(1) << ADDR_W;

    state_t                 r_state;
    logic [LEN_W-1:0]       r_len;
    logic                   r_mem_we;
    logic [ADDR_W-1:0]      r_mem_addr;
    logic [INSTR_W-1:0]     r_mem_wdata;
    logic                   r_done;
    logic                   r_error;
    logic                   r_core_rst;
    logic [ADDR_W:0]        r_word_cnt;

    logic                   w_ready;
    logic                   w_accept;
    logic                   w_data_accept;
    logic                   w_rearm;
    logic [LEN_W-1:0]       w_len;
    logic                   w_len_over;
    logic [ADDR_W:0]        w_cnt_next;
    logic                   w_last;
    logic                   w_word_ready;
    logic [INSTR_W-1:0]     w_word;

    assign w_ready       = state_accepts_bytes(r_state);
    assign w_accept      = bus.in_valid && w_ready;
    assign w_data_accept = w_accept && (r_state == DATA);
    assign w_rearm       = start && ((r_state == DONE) || (r_state == ERROR));

    // Full length as it will be once the high byte on the bus is latched.
    assign w_len      = LEN_W'({bus.in_data, r_len[7:0]});
    assign w_len_over = 33'(w_len) > c_depth;
    assign w_cnt_next = r_word_cnt + 1'b1;
    assign w_last     = (32'(w_cnt_next) == 32'(r_len));

    imem_loader_byte_packer u_packer (
        .clk        (clk),
        .rst        (rst),
        .clear      (w_rearm),
        .accept     (w_data_accept),
        .in_byte    (bus.in_data),
        .word_ready (w_word_ready),
        .word       (w_word)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= LEN_LO;
            r_len       <= '0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_done      <= 1'b0;
            r_error     <= 1'b0;
            r_core_rst  <= 1'b1;
            r_word_cnt  <= '0;
        end else begin
            r_mem_we <= 1'b0;
            case (r_state)
                LEN_LO: begin
                    if (w_accept) begin
                        r_len   <= LEN_W'(bus.in_data);
                        r_state <= LEN_HI;
                    end
                end
                LEN_HI: begin
                    if (w_accept) begin
                        r_len <= w_len;
                        if (w_len == '0) begin
                            r_state    <= DONE;
                            r_done     <= 1'b1;
                            r_core_rst <= 1'b0;
                        end else if (w_len_over) begin
                            r_state <= ERROR;
                            r_error <= 1'b1;
                        end else begin
                            r_state <= DATA;
                        end
                    end
                end
                DATA: begin
                    // Word index doubles as the write address; the count
                    // steps on the same edge that raises the write strobe.
                    if (w_word_ready) begin
                        r_mem_we    <= 1'b1;
                        r_mem_addr  <= r_word_cnt[ADDR_W-1:0];
                        r_mem_wdata <= w_word;
                        r_word_cnt  <= w_cnt_next;
                        if (w_last) begin
                            r_state <= FLUSH;
                        end
                    end
                end
                FLUSH: begin
                    r_state    <= DONE;
                    r_done     <= 1'b1;
                    r_core_rst <= 1'b0;
                end
                DONE, ERROR: begin
                    if (start) begin
                        r_state    <= LEN_LO;
                        r_done     <= 1'b0;
                        r_error    <= 1'b0;
                        r_word_cnt <= '0;
                        r_core_rst <= 1'b1;
                    end
                end
                default: begin
                    r_state <= LEN_LO;
                end
            endcase
        end
    end

    assign bus.in_ready  = w_ready;
    assign bus.mem_we    = r_mem_we;
    assign bus.mem_addr  = r_mem_addr;
    assign bus.mem_wdata = r_mem_wdata;
    assign core_rst      = r_core_rst;
    assign done          = r_done;
    assign error         = r_error;
    assign word_cnt      = r_word_cnt;

endmodule

`default_nettype wire
